// File: rtl/booth_pkg.sv
// Shared types and build-dependent constants for the sequential Booth multiplier.
// Build option: define BOOTH_RADIX4_EN for modified-Booth radix-4 (default is radix-2).
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_ADD1 = 3'd1,
    OP_SUB1 = 3'd2,
    OP_ADD2 = 3'd3,
    OP_SUB2 = 3'd4
  } recode_op_e;

`ifdef BOOTH_RADIX4_EN
  localparam bit RADIX4 = 1'b1;
`else
  localparam bit RADIX4 = 1'b0;
`endif

  // Bits consumed from the multiplier per RUN cycle.
  localparam int SHIFT = RADIX4 ? 2 : 1;

  function automatic int n_iter(input int w);
    if (RADIX4) return (w / 2) + 1;
    else        return w + 1;
  endfunction

  // Operand width after sign/zero extension.
  function automatic int ext_width(input int w);
    if (RADIX4) return w + 2;
    else        return w + 1;
  endfunction

endpackage

// File: rtl/booth_recoder.sv
// Combinational Booth recoder: {Q[1], Q[0], q_m1} -> add/subtract operation.
// Radix-2 build (BOOTH_RADIX4_EN undefined) looks only at {Q[0], q_m1}.
module booth_recoder
  import booth_pkg::*;
(
  input  logic [2:0] bits_i,
  output recode_op_e op_o
);

  always_comb begin
    op_o = OP_NONE;
    if (RADIX4) begin
      case (bits_i)
        3'b001, 3'b010: op_o = OP_ADD1;
        3'b011:         op_o = OP_ADD2;
        3'b100:         op_o = OP_SUB2;
        3'b101, 3'b110: op_o = OP_SUB1;
        default:        op_o = OP_NONE;
      endcase
    end else begin
      case (bits_i[1:0])
        2'b01:   op_o = OP_ADD1;
        2'b10:   op_o = OP_SUB1;
        default: op_o = OP_NONE;
      endcase
    end
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential Booth multiplier with valid/ready on both sides; signed/unsigned per operation.
// Build option: BOOTH_RADIX4_EN selects radix-4 recoding (W/2+1 iterations instead of W+1).
//
//  state | meaning
//  IDLE  | waiting for operands, in_ready high
//  RUN   | one recode/add/shift step per cycle, count_q iterations left
//  DONE  | product held on out_valid until out_ready
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           is_signed,
  input  logic [W-1:0]   multiplicand,
  input  logic [W-1:0]   multiplier,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);

  localparam int WI   = ext_width(W);
  localparam int WA   = WI + 2;
  localparam int N_IT = n_iter(W);
  localparam int CW   = $clog2(N_IT + 1);

  if (W < 2 || W > 32) begin : g_bad_width
    $error("booth_mult_seq: W must lie in 2..32");
  end
  if (RADIX4 && (W % 2 != 0)) begin : g_odd_width
    $error("booth_mult_seq: radix-4 build requires an even W");
  end

  state_e              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic signed [WA-1:0] a_q, a_d;
  logic [WI-1:0]       q_q, q_d;
  logic                qm1_q, qm1_d;
  logic [WI-1:0]       m_q, m_d;
  logic [2*W-1:0]      product_q, product_d;

  logic                 accept;
  logic [WI-1:0]        mcand_ext, mplier_ext;
  recode_op_e           op;
  logic signed [WA-1:0] m_wide, addend, sum;
  logic signed [WA+WI:0] cat, cat_sh;

  assign in_ready = (state_q == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  assign mcand_ext  = {{(WI-W){is_signed & multiplicand[W-1]}}, multiplicand};
  assign mplier_ext = {{(WI-W){is_signed & multiplier[W-1]}}, multiplier};

  booth_recoder u_recoder (
    .bits_i ({q_q[1], q_q[0], qm1_q}),
    .op_o   (op)
  );

  // A carries two guard bits so that -2M of the most negative operand still fits.
  assign m_wide = {{(WA-WI){m_q[WI-1]}}, m_q};

  always_comb begin
    addend = '0;
    case (op)
      OP_ADD1: addend = m_wide;
      OP_SUB1: addend = -m_wide;
      OP_ADD2: addend = m_wide <<< 1;
      OP_SUB2: addend = -(m_wide <<< 1);
      default: addend = '0;
    endcase
    sum = a_q + addend;
  end

  assign cat    = {sum, q_q, qm1_q};
  assign cat_sh = cat >>> SHIFT;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    a_d       = a_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          count_d = CW'(N_IT);
          a_d     = '0;
          q_d     = mplier_ext;
          qm1_d   = 1'b0;
          m_d     = mcand_ext;
        end
      end
      RUN: begin
        a_d   = cat_sh[WA+WI -: WA];
        q_d   = cat_sh[WI -: WI];
        qm1_d = cat_sh[0];
        if (count_q == CW'(1)) begin
          state_d   = DONE;
          count_d   = '0;
          // Low 2W bits of the shifted {A,Q}.
          product_d = cat_sh[1 +: 2*W];
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      a_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      a_q       <= a_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      product_q <= product_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign product   = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq (W=8): arithmetic reference model plus directed literals.
module tb_booth_mult_seq;

`ifdef BOOTH_RADIX4_EN
  localparam int NIT = 8 / 2 + 1;
`else
  localparam int NIT = 8 + 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        is_signed = 1'b0;
  logic [7:0]  multiplicand = '0;
  logic [7:0]  multiplier = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] product;
  logic        busy;

  booth_mult_seq #(.W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .is_signed    (is_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ops_sent = 0;
  int n_acc = 0;
  int n_ret = 0;
  bit rand_bp = 1'b0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input bit s);
    longint pa, pb;
    if (s) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end else begin
      pa = longint'(a);
      pb = longint'(b);
    end
    return 16'(pa * pb);
  endfunction

  // Reference: one op in flight; out_valid after NIT+1 cycles; product = arithmetic result.
  logic [15:0] exp_q[$];
  int  cyc = 0;
  int  acc_cyc = 0;
  bit  pending = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("in_ready_in_rst", in_ready, 1'b0);
      exp_q.delete();
      pending = 1'b0;
    end else begin
      chk("mon_in_ready", in_ready, !pending);
      chk("mon_busy", busy, pending);
      chk("mon_out_valid", out_valid, pending && (cyc - acc_cyc >= NIT + 1));
      if (out_valid && exp_q.size() > 0) chk("mon_product", product, exp_q[0]);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("mon_dup_retire", 1'b1, 1'b0);
        else void'(exp_q.pop_front());
        pending = 1'b0;
        n_ret++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(multiplicand, multiplier, is_signed));
        pending = 1'b1;
        acc_cyc = cyc;
        n_acc++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_op(input logic [7:0] a, input logic [7:0] b, input bit s);
    @(posedge clk); #1;
    in_valid = 1'b1;
    multiplicand = a;
    multiplier = b;
    is_signed = s;
    ops_sent++;
  endtask

  // Returns after the accepting edge; operands are then scrambled.
  task automatic wait_accept(output int waited);
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("accept_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    multiplicand = 8'($urandom);
    multiplier = 8'($urandom);
    is_signed = 1'($urandom);
  endtask

  task automatic wait_done(output logic [15:0] p, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
    if (!out_valid) chk("done_timeout", 1'b0, 1'b1);
    p = product;
  endtask

  task automatic directed(input string nm, input logic [7:0] a, input logic [7:0] b,
                          input bit s, input logic [15:0] exp_p);
    logic [15:0] p;
    int lat, w;
    chk({nm, "_model"}, model(a, b, s), exp_p);
    drive_op(a, b, s);
    wait_accept(w);
    wait_done(p, lat);
    chk({nm, "_product"}, p, exp_p);
    chk({nm, "_latency"}, lat, NIT + 1);
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'h01;
      2: return 8'h7F;
      3: return 8'h80;
      4: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] p;
    int lat, w;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_product", product, 16'h0000);

    directed("u7x3", 8'd7, 8'd3, 1'b0, 16'h0015);
    directed("s_m128xm128", 8'h80, 8'h80, 1'b1, 16'h4000);
    directed("s_m1x1", 8'hFF, 8'h01, 1'b1, 16'hFFFF);
    directed("s_127xm128", 8'h7F, 8'h80, 1'b1, 16'hC080);
    directed("u255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    directed("s_ffxff", 8'hFF, 8'hFF, 1'b1, 16'h0001);
    directed("zero_op", 8'h00, 8'h5A, 1'b1, 16'h0000);

    // Backpressure hold, then retire and new request in the same cycle.
    @(posedge clk); #1 out_ready = 1'b0;
    drive_op(8'd9, 8'd11, 1'b0);
    wait_accept(w);
    wait_done(p, lat);
    chk("bp_latency", lat, NIT + 1);
    for (int i = 0; i < 20; i++) begin
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_product", product, 16'h0063);
      chk("bp_in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    multiplicand = 8'd6;
    multiplier = 8'd7;
    is_signed = 1'b0;
    ops_sent++;
    @(negedge clk);
    chk("retire_cycle_in_ready", in_ready, 1'b0);
    chk("retire_cycle_out_valid", out_valid, 1'b1);
    wait_accept(w);
    chk("accept_one_clock_later", w, 0);
    wait_done(p, lat);
    chk("after_bp_product", p, 16'h002A);
    chk("after_bp_latency", lat, NIT + 1);

    // Reset while RUN has three iterations left.
    drive_op(8'd100, 8'd3, 1'b0);
    wait_accept(w);
    repeat (NIT - 3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrun_rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 1'b0);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_product", product, 16'h0000);
    directed("u5x5", 8'd5, 8'd5, 1'b0, 16'h0019);

    // Random traffic with random output backpressure; the monitor checks every result.
    rand_bp = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      drive_op(pick(), pick(), 1'($urandom));
      wait_accept(w);
    end
    rand_bp = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    for (int i = 0; i < 200 && (pending || exp_q.size() != 0); i++) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
    chk("accept_count", n_acc, ops_sent);
    chk("retire_count", n_ret, ops_sent - 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
